// File: rtl/pause_pkg.sv
// Shared constants and width helpers for the pause controller.
package pause_pkg;

  localparam int unsigned OPT_OSD_PAUSE = 0;
  localparam int unsigned OPT_DIM_EN    = 1;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned ms_cnt_width(input int unsigned dim_ms);
    return cnt_width(dim_ms);
  endfunction

  function automatic int unsigned own_osd(input int unsigned num_req);
    return num_req + 1;
  endfunction

  function automatic int unsigned own_user(input int unsigned num_req);
    return num_req;
  endfunction

endpackage

// File: rtl/pause_timer.sv
// Paused-time tracker: 1 ms prescaler, saturating ms counter and dim shift.
// Gradual fade is built only when PAUSE_CTRL_FADE_EN is defined.
module pause_timer
  import pause_pkg::*;
#(
  parameter int unsigned CLK_MHZ   = 40,
  parameter int unsigned DIM_MS    = 10000,
  parameter int unsigned DIM_SHIFT = 1,
  parameter int unsigned FADE_MS   = 250,
  localparam int unsigned MW = ms_cnt_width(DIM_MS),
  localparam int unsigned SW = cnt_width(DIM_SHIFT)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          run,
  output logic [MW-1:0] ms_count,
  output logic [SW-1:0] dim_shift
);

  localparam int unsigned PW = cnt_width(CLK_MHZ * 1000 - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_MHZ * 1000 - 1);
  localparam logic [MW-1:0] CNT_MAX    = MW'(DIM_MS);
  localparam logic [SW-1:0] SHIFT_MAX  = SW'(DIM_SHIFT);

  logic [PW-1:0] presc_q;
  logic [MW-1:0] count_q;
  logic [SW-1:0] shift_q;
  logic          ms_tick;

  assign ms_tick   = run && (presc_q == PRESC_LAST);
  assign ms_count  = count_q;
  assign dim_shift = shift_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (!run) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= ms_tick ? '0 : presc_q + 1'b1;
      if (ms_tick && (count_q != CNT_MAX)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

`ifdef PAUSE_CTRL_FADE_EN
  localparam int unsigned FW = cnt_width(FADE_MS - 1);
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_MS - 1);

  logic [FW-1:0] fade_q;

  // First step lands as soon as the counter saturates; later steps wait FADE_MS ticks.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      fade_q  <= '0;
    end else if (count_q != CNT_MAX) begin
      shift_q <= '0;
      fade_q  <= '0;
    end else if ((shift_q == '0) && (SHIFT_MAX != '0)) begin
      shift_q <= SW'(1);
      fade_q  <= '0;
    end else if (ms_tick && (shift_q != SHIFT_MAX)) begin
      if (fade_q == FADE_LAST) begin
        fade_q  <= '0;
        shift_q <= shift_q + 1'b1;
      end else begin
        fade_q <= fade_q + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= (count_q == CNT_MAX) ? SHIFT_MAX : '0;
    end
  end
`endif

endmodule

// File: rtl/pause_ctrl_multi.sv
// Merges user toggle, N pause requesters and OSD into one registered CPU freeze,
// and dims video after a long pause. Optional gradual fade: PAUSE_CTRL_FADE_EN.
module pause_ctrl_multi
  import pause_pkg::*;
#(
  parameter int unsigned RW        = 3,
  parameter int unsigned GW        = 3,
  parameter int unsigned BW        = 3,
  parameter int unsigned CLK_MHZ   = 40,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DIM_MS    = 10000,
  parameter int unsigned DIM_SHIFT = 1,
  parameter int unsigned FADE_MS   = 250
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  user_button,
  input  logic [NUM_REQ-1:0]    pause_request,
  input  logic                  OSD_STATUS,
  input  logic [1:0]            options,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  pause_cpu,
  output logic                  dim_active,
  output logic [NUM_REQ+1:0]    req_owner
);

  localparam int unsigned OWN_OSD  = own_osd(NUM_REQ);
  localparam int unsigned OWN_USER = own_user(NUM_REQ);
  localparam int unsigned MW       = ms_cnt_width(DIM_MS);
  localparam int unsigned SW       = cnt_width(DIM_SHIFT);

  logic               btn_q;
  logic               user_pause;
  logic               osd_pause;
  logic               pause_next;
  logic [NUM_REQ+1:0] owner_next;
  logic               run;
  logic [MW-1:0]      ms_count;
  logic [SW-1:0]      dim_shift;
  logic               unused_ms;

  always_comb begin
    osd_pause  = OSD_STATUS & options[OPT_OSD_PAUSE];
    pause_next = user_pause | (|pause_request) | osd_pause;
    owner_next = '0;
    owner_next[OWN_OSD]       = osd_pause;
    owner_next[OWN_USER]      = user_pause;
    owner_next[NUM_REQ-1:0]   = pause_request;
    run        = pause_cpu & options[OPT_DIM_EN];
  end

  // Count is only observable through the dim shift at this level.
  assign unused_ms = ^ms_count;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_q      <= 1'b0;
      user_pause <= 1'b0;
      pause_cpu  <= 1'b0;
      req_owner  <= '0;
    end else begin
      btn_q      <= user_button;
      if (user_button && !btn_q) begin
        user_pause <= ~user_pause;
      end
      pause_cpu  <= pause_next;
      req_owner  <= owner_next;
    end
  end

  pause_timer #(
    .CLK_MHZ   (CLK_MHZ),
    .DIM_MS    (DIM_MS),
    .DIM_SHIFT (DIM_SHIFT),
    .FADE_MS   (FADE_MS)
  ) u_timer (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .run       (run),
    .ms_count  (ms_count),
    .dim_shift (dim_shift)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rgb_out    <= '0;
      dim_active <= 1'b0;
    end else begin
      rgb_out    <= {r >> dim_shift, g >> dim_shift, b >> dim_shift};
      dim_active <= (dim_shift != '0);
    end
  end

endmodule

// File: tb/tb_pause_ctrl_multi.sv
// Directed bench for pause_ctrl_multi at CLK_MHZ=1, DIM_MS=3, DIM_SHIFT=1.
module tb_pause_ctrl_multi;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       user_button;
  logic [1:0] pause_request;
  logic       OSD_STATUS;
  logic [1:0] options;
  logic [2:0] r, g, b;
  logic [8:0] rgb_out;
  logic       pause_cpu;
  logic       dim_active;
  logic [3:0] req_owner;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  pause_ctrl_multi #(
    .RW        (3),
    .GW        (3),
    .BW        (3),
    .CLK_MHZ   (1),
    .NUM_REQ   (2),
    .DIM_MS    (3),
    .DIM_SHIFT (1),
    .FADE_MS   (1)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .user_button   (user_button),
    .pause_request (pause_request),
    .OSD_STATUS    (OSD_STATUS),
    .options       (options),
    .r             (r),
    .g             (g),
    .b             (b),
    .rgb_out       (rgb_out),
    .pause_cpu     (pause_cpu),
    .dim_active    (dim_active),
    .req_owner     (req_owner)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Toggles user_pause on the first edge; pause_cpu reflects it on return.
  task automatic press();
    user_button = 1'b1;
    tick(1);
    user_button = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    user_button = 1'b0;
    pause_request = 2'b00;
    OSD_STATUS = 1'b0;
    options = 2'b00;
    r = 3'b111; g = 3'b111; b = 3'b111;
    tick(2);
    chk("rst_pause", 16'(pause_cpu), 16'h0);
    chk("rst_owner", 16'(req_owner), 16'h0);
    chk("rst_rgb", 16'(rgb_out), 16'h0);
    chk("rst_dim", 16'(dim_active), 16'h0);
    reset = 1'b0;
    tick(1);
    chk("pass_rgb", 16'(rgb_out), 16'h1FF);

    // Button: two edges to pause_cpu, holding causes no further toggles
    user_button = 1'b1;
    tick(1);
    chk("btn_lat1", 16'(pause_cpu), 16'h0);
    tick(1);
    chk("btn_lat2", 16'(pause_cpu), 16'h1);
    chk("btn_owner", 16'(req_owner), 16'h4);
    tick(8);
    chk("btn_hold", 16'(pause_cpu), 16'h1);
    user_button = 1'b0;
    tick(2);
    chk("btn_release", 16'(pause_cpu), 16'h1);
    press();
    chk("btn_unpause", 16'(pause_cpu), 16'h0);
    chk("btn_unowner", 16'(req_owner), 16'h0);

    // External request, dim disabled
    r = 3'b101; g = 3'b010; b = 3'b110;
    pause_request = 2'b10;
    tick(1);
    chk("req_lat", 16'(pause_cpu), 16'h1);
    chk("req_owner", 16'(req_owner), 16'h2);
    tick(4);
    chk("req_hold5", 16'(pause_cpu), 16'h1);
    chk("req_rgb", 16'(rgb_out), 16'h156);
    pause_request = 2'b00;
    tick(1);
    chk("req_drop", 16'(pause_cpu), 16'h0);

    // Button edge in the same cycle a request deasserts still toggles
    pause_request = 2'b01;
    tick(2);
    pause_request = 2'b00;
    press();
    chk("simul_pause", 16'(pause_cpu), 16'h1);
    chk("simul_owner", 16'(req_owner), 16'h4);
    press();
    chk("simul_unpause", 16'(pause_cpu), 16'h0);

    // OSD gating
    OSD_STATUS = 1'b1;
    tick(2);
    chk("osd_nogate", 16'(pause_cpu), 16'h0);
    chk("osd_noowner", 16'(req_owner), 16'h0);
    options = 2'b01;
    tick(1);
    chk("osd_pause", 16'(pause_cpu), 16'h1);
    chk("osd_owner", 16'(req_owner), 16'h8);
    OSD_STATUS = 1'b0;
    options = 2'b00;
    tick(1);
    chk("osd_clear", 16'(pause_cpu), 16'h0);

    // Dimming: visible 3002 edges after pause_cpu rises (count hits 3 at 3000,
    // shift registers at 3001, video at 3002)
    r = 3'b111; g = 3'b111; b = 3'b111;
    options = 2'b10;
    press();
    chk("dim_paused", 16'(pause_cpu), 16'h1);
    tick(3001);
    chk("dim_pre_rgb", 16'(rgb_out), 16'h1FF);
    chk("dim_pre_act", 16'(dim_active), 16'h0);
    tick(1);
    chk("dim_rgb", 16'(rgb_out), 16'h0DB);
    chk("dim_act", 16'(dim_active), 16'h1);
    r = 3'b101; g = 3'b010; b = 3'b110;
    tick(1);
    chk("dim_rgb2", 16'(rgb_out), 16'h08B);
    r = 3'b111; g = 3'b111; b = 3'b111;
    press();
    chk("undim_cpu", 16'(pause_cpu), 16'h0);
    tick(2);
    chk("undim_hold", 16'(rgb_out), 16'h0DB);
    tick(1);
    chk("undim_rgb", 16'(rgb_out), 16'h1FF);
    chk("undim_act", 16'(dim_active), 16'h0);

    // Asynchronous reset mid-pause, then the counter starts over
    press();
    tick(2500);
    chk("pre_rst_dim", 16'(dim_active), 16'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_pause", 16'(pause_cpu), 16'h0);
    chk("arst_owner", 16'(req_owner), 16'h0);
    chk("arst_rgb", 16'(rgb_out), 16'h0);
    tick(1);
    reset = 1'b0;
    pause_request = 2'b01;
    tick(1);
    chk("post_rst_pause", 16'(pause_cpu), 16'h1);
    chk("post_rst_owner", 16'(req_owner), 16'h1);
    tick(3001);
    chk("post_rst_nodim", 16'(rgb_out), 16'h1FF);
    tick(1);
    chk("post_rst_dim", 16'(rgb_out), 16'h0DB);
    pause_request = 2'b00;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pause_ctrl_multi.md
Name: pause_ctrl_multi

Overview:
- Parametrised successor to the core's fixed 3/3/3-bit pause block.
- Merges a user pause toggle, N independent pause requesters (hiscore, NVRAM, debugger, ...) and an OSD-open condition into one registered CPU freeze.
- Dims the RGB stream after a programmable idle time while paused.
- Sits between core video/inputs and arcade_video. Drives `pause_cpu` to the core and audio mute.

Parameters:
- RW, 3, red channel width in bits
- GW, 3, green channel width in bits
- BW, 3, blue channel width in bits
- CLK_MHZ, 40, clk_sys frequency in MHz; used for the 1 ms tick
- NUM_REQ, 2, number of external pause request inputs (≥1)
- DIM_MS, 10000, paused time in ms before dimming starts
- DIM_SHIFT, 1, right-shift applied to each colour channel when fully dimmed (≤ min(RW,GW,BW))
- FADE_MS, 250, ms per shift step; used only with the optional feature

Ports:
- clk_sys, in, 1, system clock
- reset, in, 1, asynchronous active-high reset
- user_button, in, 1, level input from the joystick pause button
- pause_request, in, NUM_REQ, per-source level request; any bit high forces pause
- OSD_STATUS, in, 1, high while OSD is open
- options, in, 2, bit0 = pause when OSD open; bit1 = dim enable
- r, in, RW, red input
- g, in, GW, green input
- b, in, BW, blue input
- rgb_out, out, RW+GW+BW, {r,g,b} output, possibly dimmed
- pause_cpu, out, 1, registered freeze to the core
- dim_active, out, 1, high while any dim shift > 0
- req_owner, out, NUM_REQ+2, one-hot-ish status: {osd, user, requests} currently asserting pause

Behaviour:
- Reset: all outputs 0; `user_pause` = 0; `btn_q` = 0; prescaler, ms counter and shift cleared. Reset may assert mid-pause; everything clears immediately and asynchronously.
- Button edge: `btn_q` registers `user_button`. A rising edge (`user_button` & ~`btn_q`) toggles `user_pause`. Holding the button produces no further toggles.
- Pause combine: `pause_next` = `user_pause` | (|`pause_request`) | (`OSD_STATUS` & `options[0]`). `pause_cpu` <= `pause_next`, giving 1-cycle latency from a request or OSD change. A button edge takes 2 cycles to reach `pause_cpu` (toggle, then register). `req_owner` is registered in the same cycle as `pause_cpu`.
- Simultaneous events: a button edge in the same cycle a request deasserts still toggles. `pause_cpu` follows the OR of all sources; no source priority.
- Timer (`pause_timer`):
  - Prescaler counts 0..CLK_MHZ*1000-1 while `pause_cpu` & `options[1]`; wrap produces a 1-cycle `ms_tick`.
  - ms counter width = $clog2(DIM_MS+1). It increments on `ms_tick` and saturates at DIM_MS; it does not wrap.
  - Prescaler and counter clear synchronously in any cycle where `pause_cpu` = 0 or `options[1]` = 0.
- Dim: when the counter equals DIM_MS, shift <= DIM_SHIFT. Shift returns to 0 the cycle after the counter clears.
- Video output: registered, 1-cycle latency. Each channel is logically right-shifted by the current shift, zero-filled, so width is preserved. With shift = 0, `rgb_out` = {r,g,b} delayed by one clock.
- `dim_active` = (shift != 0), registered with `rgb_out`.

Optional Feature:
- Macro: PAUSE_CTRL_FADE_EN.
- Defined: after DIM_MS is reached, shift increments by 1 every FADE_MS ms tick until it reaches DIM_SHIFT, giving a gradual fade. Unpause restores shift = 0 in one step.
- Undefined: shift jumps 0 → DIM_SHIFT at DIM_MS; FADE_MS is ignored.

Decomposition:
- Package `pause_pkg`:
  - OPT_OSD_PAUSE = 0
  - OPT_DIM_EN = 1
  - localparam function for the ms-counter width
  - `req_owner` bit index constants: OWN_OSD = NUM_REQ+1, OWN_USER = NUM_REQ
- Sub-module `pause_timer`: prescaler, saturating ms counter and (with the feature) fade step counter. Outputs `ms_count` and `dim_shift`. The top level holds edge detection, pause combine and the video register.

Test Plan (sim params CLK_MHZ=1, DIM_MS=3, DIM_SHIFT=1, NUM_REQ=2, RW=GW=BW=3):
- Reset, then `user_button` 0→1 held 10 cycles → `pause_cpu` = 1 exactly 2 cycles after the edge; stays 1; `req_owner` = 4'b0100. Second press → `pause_cpu` = 0.
- `pause_request` = 2'b10 for 5 cycles, `options` = 0 → `pause_cpu` high cycles 1..5 after assertion; `req_owner` = 4'b0010; `rgb_out` never dimmed.
- `OSD_STATUS` = 1 with `options[0]` = 0 → no pause. With `options[0]` = 1 → `pause_cpu` = 1 next cycle; `req_owner` = 4'b1000.
- Paused, `options[1]` = 1, input r=g=b=3'b111 → `rgb_out` = 9'h1FF until cycle 3000 after pause. Then 9'b011011011 and `dim_active` = 1. Drop pause → 9'h1FF one cycle after shift clears.
- Paused 2500 cycles, `reset` pulse → all outputs 0 asynchronously. After release, counter restarts from 0 and no dim before a further 3000 paused cycles.
- Fade build (DIM_SHIFT=2, FADE_MS=1) → shift 1 at cycle 3000, 2 at cycle 4000. `rgb_out` for input 3'b111 steps 111 → 011 → 001 per channel.
